// File: rtl/fifo_read_adapter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_read_adapter_pkg                                        |
// | Description : Shared definitions for the FIFO read adapter: control state  |
// |               encoding and the data width shared with the FIFO.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fifo_read_adapter_pkg;

  // Default data width of the team FIFO; the adapter defaults to the same.
  localparam int unsigned c_FIFO_DATA_WIDTH = 16;

  // Control state encoding, explicit 2-bit width.
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACTIVE = 2'd1;
  localparam logic [1:0] c_ST_FLUSH  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = c_ST_IDLE,
    ACTIVE = c_ST_ACTIVE,
    FLUSH  = c_ST_FLUSH
  } state_e;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : skid_buffer                                                  |
// | Description : Circular buffer with push/pop/clear, occupancy count and     |
// |               registered head data. The writer must never push when full.  |
// | Ports       : clk, rst_n     - clock, async active-low reset               |
// |               i_push/i_data  - write i_data at the tail                    |
// |               i_pop          - advance the head                            |
// |               i_clear        - empty the buffer (wins over push/pop)       |
// |               o_data         - head entry                                  |
// |               o_count        - occupancy, 0..DEPTH                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module skid_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2     // power of two, 2..8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_PTR_W:0]      r_count;

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= r_tail + 1'b1;   // pointers wrap naturally (power of two)
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_head];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fifo_read_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_read_adapter                                            |
// | Description : Reads the synchronous FIFO (one-cycle read latency) and      |
// |               presents the words as a valid/ready stream through a skid    |
// |               buffer, so the sink may stall on any cycle.                  |
// | Ports       : clk, rst_n            - clock, async active-low reset        |
// |               enable, flush         - read permit, discard all data        |
// |               fifo_empty/data_out/underflow, fifo_rd_en - FIFO read port   |
// |               m_valid/m_ready/m_data - output stream                       |
// |               busy, words_read, underflow_err - status                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_read_adapter
  import fifo_read_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = c_FIFO_DATA_WIDTH,
  parameter int BUF_DEPTH  = 2,    // power of two, 2..8
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic                  underflow_err
);

  localparam int               c_OCC_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [c_OCC_W:0] c_DEPTH_V = (c_OCC_W + 1)'(BUF_DEPTH);

  state_e                r_state;
  logic                  r_pending;
  logic [CNT_WIDTH-1:0]  r_words_read;
  logic                  r_underflow_err;

  logic [c_OCC_W-1:0]    w_count;
  logic [c_OCC_W:0]      w_used;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_head_data;

  assign w_valid = (w_count != '0);

  // A pop is dropped in the flush cycle since the buffer is being cleared.
  assign w_pop = w_valid & m_ready & ~flush;

  // Slots committed after this edge: stored words plus the beat in flight,
  // less the word leaving now. Crediting the pop is what lets a 2-entry
  // buffer sustain one read per cycle, and it still never overflows: the
  // beat requested now lands in a slot that is free after this edge.
  assign w_used = {1'b0, w_count}
                + {{c_OCC_W{1'b0}}, r_pending}
                - {{c_OCC_W{1'b0}}, w_pop};

  assign w_rd_en = (r_state == ACTIVE) & ~flush & ~fifo_empty & (w_used < c_DEPTH_V);

  // Beats returning in the flush cycle or in the FLUSH state belong to
  // pre-flush requests; the FLUSH state acts as the drop flag for them.
  assign w_capture = r_pending & ~fifo_underflow & ~flush & (r_state != FLUSH);

  skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_capture),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  (fifo_data_out),
    .o_data  (w_head_data),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= FLUSH;              // held while flush stays high
    end else if (enable) begin
      r_state <= ACTIVE;
    end else begin
      r_state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending       <= 1'b0;
      r_words_read    <= '0;
      r_underflow_err <= 1'b0;
    end else begin
      // w_rd_en is already low under flush, so pending clears on the flush edge.
      r_pending <= w_rd_en;
      if (w_pop) begin
        r_words_read <= r_words_read + 1'b1;
      end
      if (r_pending && fifo_underflow) begin
        r_underflow_err <= 1'b1;
      end
    end
  end

  assign fifo_rd_en    = w_rd_en;
  assign m_valid       = w_valid;
  assign m_data        = w_head_data;
  assign busy          = w_valid | r_pending;
  assign words_read    = r_words_read;
  assign underflow_err = r_underflow_err;

endmodule
`default_nettype wire
